// File: rtl/adc_sample_capture_if.sv
// Signal bundle between the ADC capture block (master) and the trigger, ADC and control-loop side (slave).
interface adc_sample_capture_if #(
  parameter int DATA_W = 12
);
  logic              adc_trig;
  logic              update;
  logic              adc_sdo;
  logic              adc_convst;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] sample;
  logic              sample_vld;
  logic [DATA_W-1:0] sample_upd;
  logic              busy;
  logic              overrun;

  modport master (
    input  adc_trig, update, adc_sdo,
    output adc_convst, adc_cs_n, adc_sclk, sample, sample_vld, sample_upd, busy, overrun
  );

  modport slave (
    output adc_trig, update, adc_sdo,
    input  adc_convst, adc_cs_n, adc_sclk, sample, sample_vld, sample_upd, busy, overrun
  );
endinterface

// File: rtl/adc_sample_capture.sv
// Trigger-rise -> convert -> serial readback of an SPI-style ADC; result out 1+CONV_CYC+2*SCLK_DIV*DATA_W cycles after the rise.
// No backpressure: a trigger rise while busy is dropped and flagged on overrun.
module adc_sample_capture #(
  parameter int DATA_W   = 12,
  parameter int SCLK_DIV = 4,
  parameter int CONV_CYC = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_sample_capture_if.master bus
);

  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CONV_W = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CONV_W-1:0]   conv_cnt, conv_nxt;
  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [HALF_W-1:0]   half_cnt, half_nxt;
  logic [DATA_W-1:0]   shift_q, shift_nxt;
  logic                sclk_q, sclk_nxt;
  logic                trig_q;
  logic                rise;

  logic                convst_q;
  logic                cs_n_q;
  logic                busy_q;
  logic                vld_q;
  logic                ovr_q;
  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   upd_q;

  assign rise = bus.adc_trig & ~trig_q;

  always_comb begin
    state_nxt = state;
    conv_nxt  = conv_cnt;
    div_nxt   = div_cnt;
    half_nxt  = half_cnt;
    shift_nxt = shift_q;
    sclk_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = CONV;
          conv_nxt  = CONV_LOAD;
        end
      end
      CONV: begin
        if (conv_cnt == '0) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          half_nxt  = '0;
        end else begin
          conv_nxt = conv_cnt - CONV_W'(1);
        end
      end
      SHIFT: begin
        sclk_nxt = sclk_q;
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          // The final high half-period ends the frame; sclk drops as we leave.
          if (half_cnt == HALF_LAST) begin
            state_nxt = DONE;
            sclk_nxt  = 1'b0;
          end else begin
            half_nxt = half_cnt + HALF_W'(1);
            sclk_nxt = ~sclk_q;
            if (!sclk_q) begin
              shift_nxt = {shift_q[DATA_W-2:0], bus.adc_sdo};
            end
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      conv_cnt <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b0;
      trig_q   <= 1'b1;
      convst_q <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      sample_q <= '0;
      upd_q    <= '0;
    end else begin
      state    <= state_nxt;
      conv_cnt <= conv_nxt;
      div_cnt  <= div_nxt;
      half_cnt <= half_nxt;
      shift_q  <= shift_nxt;
      sclk_q   <= sclk_nxt;
      trig_q   <= bus.adc_trig;
      convst_q <= (state_nxt == CONV);
      cs_n_q   <= (state_nxt != SHIFT);
      busy_q   <= (state_nxt != IDLE);
      vld_q    <= (state_nxt == DONE);
      ovr_q    <= rise && (state != IDLE);
      if (state_nxt == DONE) begin
        sample_q <= shift_q;
      end
      // Bypass so an update landing on the publish edge sees the fresh result.
      if (bus.update) begin
        upd_q <= (state_nxt == DONE) ? shift_q : sample_q;
      end
    end
  end

  assign bus.adc_convst = convst_q;
  assign bus.adc_cs_n   = cs_n_q;
  assign bus.adc_sclk   = sclk_q;
  assign bus.sample     = sample_q;
  assign bus.sample_vld = vld_q;
  assign bus.sample_upd = upd_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture: default build plus a fast 16-bit build, each with a behavioural serial ADC.
module tb_adc_sample_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_sample_capture_if #(.DATA_W(12)) bus0 ();
  adc_sample_capture_if #(.DATA_W(16)) bus6 ();

  adc_sample_capture u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  adc_sample_capture #(.DATA_W(16), .SCLK_DIV(1), .CONV_CYC(1)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];
  logic [15:0] exp6_q[$];

  // ADC models: MSB presented while deselected, next bit after each sclk rise.
  logic [11:0] adc_data0 = '0;
  logic [15:0] adc_data6 = '0;
  int   nr0 = 0, nr6 = 0;
  logic sp0 = 1'b0, sp6 = 1'b0;

  always @(negedge clk) begin
    if (bus0.adc_cs_n) begin
      nr0 = 0;
      bus0.adc_sdo = adc_data0[11];
    end else begin
      if (bus0.adc_sclk && !sp0) nr0++;
      bus0.adc_sdo = (nr0 < 12) ? adc_data0[11-nr0] : 1'b0;
    end
    sp0 = bus0.adc_sclk;
  end

  always @(negedge clk) begin
    if (bus6.adc_cs_n) begin
      nr6 = 0;
      bus6.adc_sdo = adc_data6[15];
    end else begin
      if (bus6.adc_sclk && !sp6) nr6++;
      bus6.adc_sdo = (nr6 < 16) ? adc_data6[15-nr6] : 1'b0;
    end
    sp6 = bus6.adc_sclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic capture0(input logic [11:0] d, input int upd_at, input int retrig_at,
                          output int lat, output logic [11:0] got, output logic [11:0] got_upd,
                          output int n_conv, output int n_rise, output int first_hi, output int last_hi,
                          output int n_vld, output int n_ovr, output int ovr_at);
    logic sp;
    adc_data0 = d;
    exp_q.push_back(d);
    lat = -1; got = '0; got_upd = '0; n_conv = 0; n_rise = 0; first_hi = -1; last_hi = -1;
    n_vld = 0; n_ovr = 0; ovr_at = -1; sp = 1'b0;
    @(negedge clk);
    bus0.adc_trig = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 2) bus0.adc_trig = 1'b0;
      if (retrig_at > 0 && n == retrig_at) bus0.adc_trig = 1'b1;
      if (retrig_at > 0 && n == retrig_at + 3) bus0.adc_trig = 1'b0;
      if (upd_at > 0) bus0.update = (n == upd_at);
      if (bus0.adc_convst) n_conv++;
      if (bus0.adc_sclk && !sp) begin
        n_rise++;
        if (first_hi < 0) first_hi = n;
        last_hi = n;
      end
      sp = bus0.adc_sclk;
      if (bus0.overrun) begin
        n_ovr++;
        if (ovr_at < 0) ovr_at = n;
      end
      if (bus0.sample_vld) begin
        n_vld++;
        if (lat < 0) begin
          lat = n;
          got = bus0.sample;
          got_upd = bus0.sample_upd;
        end
      end
      if (lat > 0 && n >= lat + 10) break;
    end
    bus0.update = 1'b0;
    bus0.adc_trig = 1'b0;
  endtask

  task automatic capture6(input logic [15:0] d, output int lat, output logic [15:0] got, output int n_rise);
    logic sp;
    adc_data6 = d;
    exp6_q.push_back(d);
    lat = -1; got = '0; n_rise = 0; sp = 1'b0;
    @(negedge clk);
    bus6.adc_trig = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 2) bus6.adc_trig = 1'b0;
      if (bus6.adc_sclk && !sp) n_rise++;
      sp = bus6.adc_sclk;
      if (bus6.sample_vld) begin
        lat = n;
        got = bus6.sample;
        break;
      end
    end
    bus6.adc_trig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus0.adc_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", bus0.adc_cs_n); end
    total++; if (bus0.adc_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", bus0.adc_sclk); end
    total++; if (bus0.adc_convst !== 1'b0) begin bad++; $display("FAIL reset_convst: got %b want 0", bus0.adc_convst); end
    total++; if (bus0.sample !== 12'h000) begin bad++; $display("FAIL reset_sample: got %h want 000", bus0.sample); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    total++; if (bus0.sample_upd !== 12'h000) begin bad++; $display("FAIL reset_upd: got %h want 000", bus0.sample_upd); end
    total++; if (bus6.adc_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n6: got %b want 1", bus6.adc_cs_n); end
  endtask

  task automatic test_capture();
    int lat, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at;
    logic [11:0] got, got_upd, e;
    capture0(12'hA5C, 0, 0, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL cap_sample: got %h want %h", got, e); end
    total++; if (lat !== 137) begin bad++; $display("FAIL cap_latency: got %0d want 137", lat); end
    total++; if (n_conv !== 40) begin bad++; $display("FAIL cap_convst_len: got %0d want 40", n_conv); end
    total++; if (n_rise !== 12) begin bad++; $display("FAIL cap_sclk_rises: got %0d want 12", n_rise); end
    total++; if (first_hi !== 45) begin bad++; $display("FAIL cap_first_sclk: got %0d want 45", first_hi); end
    total++; if (last_hi !== 133) begin bad++; $display("FAIL cap_last_sclk: got %0d want 133", last_hi); end
    total++; if (n_vld !== 1) begin bad++; $display("FAIL cap_vld_count: got %0d want 1", n_vld); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL cap_busy_after: got %b want 0", bus0.busy); end
  endtask

  task automatic test_update();
    int lat, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at;
    logic [11:0] got, got_upd, e, upd_before;
    upd_before = bus0.sample_upd;
    capture0(12'h123, 0, 0, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL upd_sample1: got %h want %h", got, e); end
    total++; if (bus0.sample_upd !== upd_before) begin bad++; $display("FAIL upd_no_strobe: got %h want %h", bus0.sample_upd, upd_before); end
    @(negedge clk); bus0.update = 1'b1;
    @(negedge clk); bus0.update = 1'b0;
    total++; if (bus0.sample_upd !== 12'h123) begin bad++; $display("FAIL upd_latch: got %h want 123", bus0.sample_upd); end
    capture0(12'h456, 136, 0, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL upd_sample2: got %h want %h", got, e); end
    total++; if (got_upd !== 12'h456) begin bad++; $display("FAIL upd_bypass: got %h want 456", got_upd); end
  endtask

  task automatic test_overrun();
    int lat, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at;
    logic [11:0] got, got_upd, e;
    capture0(12'h3C7, 0, 20, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ovr_sample: got %h want %h", got, e); end
    total++; if (ovr_at !== 21) begin bad++; $display("FAIL ovr_when: got %0d want 21", ovr_at); end
    total++; if (n_ovr !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr); end
    total++; if (n_vld !== 1) begin bad++; $display("FAIL ovr_vld_count: got %0d want 1", n_vld); end
    total++; if (lat !== 137) begin bad++; $display("FAIL ovr_latency: got %0d want 137", lat); end
    capture0(12'h0F0, 0, 137, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ovr_done_sample: got %h want %h", got, e); end
    total++; if (ovr_at !== 138) begin bad++; $display("FAIL ovr_done_when: got %0d want 138", ovr_at); end
    total++; if (n_vld !== 1) begin bad++; $display("FAIL ovr_done_vld: got %0d want 1", n_vld); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL ovr_done_busy: got %b want 0", bus0.busy); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at, vld_seen, busy_seen;
    logic [11:0] got, got_upd, e;
    adc_data0 = 12'hABC;
    @(negedge clk);
    bus0.adc_trig = 1'b1;
    repeat (86) @(negedge clk);
    total++; if (bus0.adc_cs_n !== 1'b0) begin bad++; $display("FAIL rst_pre_cs_n: got %b want 0", bus0.adc_cs_n); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus0.adc_cs_n !== 1'b1) begin bad++; $display("FAIL rst_async_cs_n: got %b want 1", bus0.adc_cs_n); end
    total++; if (bus0.adc_sclk !== 1'b0) begin bad++; $display("FAIL rst_async_sclk: got %b want 0", bus0.adc_sclk); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", bus0.busy); end
    total++; if (bus0.sample !== 12'h000) begin bad++; $display("FAIL rst_sample: got %h want 000", bus0.sample); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vld_seen = 0; busy_seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus0.sample_vld) vld_seen++;
      if (bus0.busy) busy_seen++;
    end
    total++; if (vld_seen !== 0) begin bad++; $display("FAIL rst_held_trig_vld: got %0d want 0", vld_seen); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL rst_held_trig_busy: got %0d want 0", busy_seen); end
    total++; if (bus0.sample !== 12'h000) begin bad++; $display("FAIL rst_sample_after: got %h want 000", bus0.sample); end
    bus0.adc_trig = 1'b0;
    repeat (2) @(negedge clk);
    capture0(12'h5A3, 0, 0, lat, got, got_upd, n_conv, n_rise, first_hi, last_hi, n_vld, n_ovr, ovr_at);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL rst_recapture: got %h want %h", got, e); end
    total++; if (lat !== 137) begin bad++; $display("FAIL rst_recapture_lat: got %0d want 137", lat); end
  endtask

  task automatic test_fast_16bit();
    int lat, n_rise;
    logic [15:0] got, e;
    capture6(16'hFFFF, lat, got, n_rise);
    e = exp6_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL fast_ones: got %h want %h", got, e); end
    total++; if (lat !== 34) begin bad++; $display("FAIL fast_ones_lat: got %0d want 34", lat); end
    total++; if (n_rise !== 16) begin bad++; $display("FAIL fast_ones_rises: got %0d want 16", n_rise); end
    capture6(16'h0000, lat, got, n_rise);
    e = exp6_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL fast_zeros: got %h want %h", got, e); end
    total++; if (lat !== 34) begin bad++; $display("FAIL fast_zeros_lat: got %0d want 34", lat); end
    capture6(16'hC3A5, lat, got, n_rise);
    e = exp6_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL fast_pattern: got %h want %h", got, e); end
  endtask

  initial begin
    bus0.adc_trig = 1'b0;
    bus0.update   = 1'b0;
    bus6.adc_trig = 1'b0;
    bus6.update   = 1'b0;
    test_reset();
    test_capture();
    test_update();
    test_overrun();
    test_reset_mid_shift();
    test_fast_16bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
